// File: rtl/game_fsm.sv
// game_fsm: frame-paced game controller sequencing erase, update and draw
// passes for the bird/wall game, tracking score and a buffered flap request.
// Optional build macro GAME_PAUSE_EN adds a pause input that freezes the game
// in WAIT_FRAME and ignores flap requests while asserted.
module game_fsm #(
   parameter int FRAME_CYCLES = 833333
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       flap,
   input  logic       finished_draw,
   input  logic       collision,
   input  logic       wall_passed,
`ifdef GAME_PAUSE_EN
   input  logic       pause,
`endif
   output logic [3:0] cur_state,
   output logic       update,
   output logic       flap_out,
   output logic [7:0] score,
   output logic       game_over
);

   typedef enum logic [3:0] {
      DRAW_BIRD     = 4'd0,
      DRAW_WALL_TOP = 4'd1,
      DRAW_WALL_BOT = 4'd2,
      ERASE         = 4'd3,
      UPDATE        = 4'd4,
      WAIT_FRAME    = 4'd5,
      IDLE          = 4'd6,
      GAME_OVER     = 4'd7
   } state_e;

   localparam logic [19:0] LAST_COUNT = 20'(FRAME_CYCLES - 1);

   state_e      state_q;
   state_e      next_state;
   logic [19:0] frame_cnt;
   logic        frame_tick;
   logic        flap_pending;
   logic        flap_pending_next;
   logic [7:0]  score_next;
   logic        paused;

`ifdef GAME_PAUSE_EN
   assign paused = pause;
`else
   assign paused = 1'b0;
`endif

   assign frame_tick = (frame_cnt == LAST_COUNT);
   assign cur_state  = state_q;

   // Free-running frame counter, independent of how long drawing takes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_cnt <= 20'd0;
      end else if (frame_tick) begin
         frame_cnt <= 20'd0;
      end else begin
         frame_cnt <= frame_cnt + 20'd1;
      end
   end

   // State, score and pending-flap registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         score        <= 8'd0;
         flap_pending <= 1'b0;
      end else begin
         state_q      <= next_state;
         score        <= score_next;
         flap_pending <= flap_pending_next;
      end
   end

   // Next-state selection; unused encodings fall back to IDLE.
   always_comb begin
      next_state = state_q;
      case (state_q)
         IDLE: begin
            if (start) next_state = ERASE;
         end
         ERASE: begin
            if (finished_draw) next_state = UPDATE;
         end
         UPDATE: begin
            next_state = DRAW_BIRD;
         end
         DRAW_BIRD: begin
            if (finished_draw) next_state = DRAW_WALL_TOP;
         end
         DRAW_WALL_TOP: begin
            if (finished_draw) next_state = DRAW_WALL_BOT;
         end
         DRAW_WALL_BOT: begin
            if (finished_draw) next_state = collision ? GAME_OVER : WAIT_FRAME;
         end
         WAIT_FRAME: begin
            if (frame_tick && !paused) next_state = ERASE;
         end
         GAME_OVER: begin
            if (start) next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Flap buffering: latched during play, consumed by UPDATE, dropped when not playing.
   always_comb begin
      flap_pending_next = flap_pending;
      case (state_q)
         ERASE, DRAW_BIRD, DRAW_WALL_TOP, DRAW_WALL_BOT, WAIT_FRAME: begin
            if (flap && !paused) flap_pending_next = 1'b1;
         end
         default: begin
            flap_pending_next = 1'b0;
         end
      endcase
   end

   // Score clears when a new game starts and saturates at 255 while counting walls.
   always_comb begin
      score_next = score;
      if (state_q == IDLE && start) begin
         score_next = 8'd0;
      end else if (state_q == UPDATE && wall_passed && score != 8'hFF) begin
         score_next = score + 8'd1;
      end
   end

   // Datapath strobes decoded from the registered state.
   always_comb begin
      update    = 1'b0;
      flap_out  = 1'b0;
      game_over = 1'b0;
      if (state_q == UPDATE) begin
         update   = 1'b1;
         flap_out = flap_pending | flap;
      end
      if (state_q == GAME_OVER) begin
         game_over = 1'b1;
      end
   end

endmodule

// File: tb/tb_game_fsm.sv
// tb_game_fsm: directed scenarios plus randomized play checked against a
// behavioural model of the game rules, using a short 16-cycle frame.
module tb_game_fsm;

   localparam int FC = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       flap = 1'b0;
   logic       finished_draw = 1'b0;
   logic       collision = 1'b0;
   logic       wall_passed = 1'b0;
`ifdef GAME_PAUSE_EN
   logic       pause = 1'b0;
`endif
   logic [3:0] cur_state;
   logic       update;
   logic       flap_out;
   logic [7:0] score;
   logic       game_over;

   int vec_count = 0;
   int miscompares = 0;

   int m_state = 6;
   int m_score = 0;
   int m_cyc = 0;
   int m_dwell = 0;
   bit m_pend = 1'b0;
   bit auto_fd = 1'b0;

   game_fsm #(.FRAME_CYCLES(FC)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .flap(flap),
      .finished_draw(finished_draw),
      .collision(collision),
      .wall_passed(wall_passed),
`ifdef GAME_PAUSE_EN
      .pause(pause),
`endif
      .cur_state(cur_state),
      .update(update),
      .flap_out(flap_out),
      .score(score),
      .game_over(game_over)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Reference model of the game rules; frame ticks come from edges since reset.
   always @(posedge clk or posedge reset) begin : model
      int  ns;
      bit  np;
      bit  tick;
      if (reset) begin
         m_state = 6;
         m_score = 0;
         m_pend  = 1'b0;
         m_cyc   = 0;
         m_dwell = 0;
      end else begin
         tick = ((m_cyc % FC) == FC - 1);
         ns = m_state;
         np = m_pend;
         case (m_state)
            6: if (start) begin ns = 3; m_score = 0; end
            3: if (finished_draw) ns = 4;
            4: begin
               ns = 0;
               if (wall_passed) m_score = (m_score + 1 > 255) ? 255 : m_score + 1;
            end
            0: if (finished_draw) ns = 1;
            1: if (finished_draw) ns = 2;
            2: if (finished_draw) ns = collision ? 7 : 5;
            5: if (tick) ns = 3;
            7: if (start) ns = 6;
            default: ns = 6;
         endcase
         if (m_state == 6 || m_state == 7 || m_state == 4) np = 1'b0;
         else if (flap) np = 1'b1;
         m_dwell = (ns == m_state) ? m_dwell + 1 : 0;
         m_state = ns;
         m_pend  = np;
         m_cyc++;
      end
   end

   // Advance one clock; optionally pulse finished_draw on a draw state's third cycle.
   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
      if (auto_fd) finished_draw = (m_dwell == 2) && (m_state <= 3);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      start = 1'b0; flap = 1'b0; finished_draw = 1'b0;
      collision = 1'b0; wall_passed = 1'b0; auto_fd = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      next_cycle();
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b1;
      flap = 1'b1;
      finished_draw = 1'b1;
      next_cycle();
      next_cycle();
      vec_count++;
      if (cur_state !== 4'd6 || score !== 8'd0 || update !== 1'b0 || flap_out !== 1'b0 || game_over !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_hold: state=%0d score=%0d upd=%b fo=%b go=%b, want 6 0 0 0 0",
                  cur_state, score, update, flap_out, game_over);
      end
      flap = 1'b0;
      finished_draw = 1'b0;
      start = 1'b0;
      reset = 1'b0;
      start = 1'b1;
      #1;
      vec_count++;
      if (cur_state !== 4'd6) begin
         miscompares++;
         $display("[TB] FAIL start_idle: state=%0d want 6", cur_state);
      end
      next_cycle();
      start = 1'b0;
      #1;
      vec_count++;
      if (cur_state !== 4'd3 || score !== 8'd0) begin
         miscompares++;
         $display("[TB] FAIL start_erase: state=%0d score=%0d want 3 0", cur_state, score);
      end
   endtask

   task automatic test_frame_sequence();
      logic [3:0] seen[$];
      logic [3:0] exp_seq[6];
      logic [3:0] last;
      int wrap_pos;
      exp_seq = '{4'd4, 4'd0, 4'd1, 4'd2, 4'd5, 4'd3};
      last = cur_state;
      wrap_pos = -1;
      auto_fd = 1'b1;
      for (int i = 0; i < 200 && seen.size() < 6; i++) begin
         next_cycle();
         if (cur_state !== last) begin
            seen.push_back(cur_state);
            if (last == 4'd5 && cur_state == 4'd3) wrap_pos = m_cyc % FC;
            last = cur_state;
         end
      end
      auto_fd = 1'b0;
      finished_draw = 1'b0;
      for (int i = 0; i < 6; i++) begin
         vec_count++;
         if (i >= seen.size()) begin
            miscompares++;
            $display("[TB] FAIL frame_seq[%0d]: no transition observed, want %0d", i, exp_seq[i]);
         end else if (seen[i] !== exp_seq[i]) begin
            miscompares++;
            $display("[TB] FAIL frame_seq[%0d]: state=%0d want %0d", i, seen[i], exp_seq[i]);
         end
      end
      vec_count++;
      if (wrap_pos != 0) begin
         miscompares++;
         $display("[TB] FAIL frame_wrap: erase entered at count pos %0d want 0", wrap_pos);
      end
   endtask

   task automatic test_flap();
      do_reset();
      pulse_start();
      auto_fd = 1'b1;
      for (int i = 0; i < 200 && m_state != 5; i++) next_cycle();
      flap = 1'b1;
      next_cycle();
      flap = 1'b0;
      for (int i = 0; i < 200 && m_state != 4; i++) next_cycle();
      vec_count++;
      if (cur_state !== 4'd4 || update !== 1'b1 || flap_out !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL flap_taken: state=%0d upd=%b fo=%b want 4 1 1", cur_state, update, flap_out);
      end
      next_cycle();
      for (int i = 0; i < 200 && m_state != 4; i++) next_cycle();
      vec_count++;
      if (cur_state !== 4'd4 || update !== 1'b1 || flap_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL flap_consumed: state=%0d upd=%b fo=%b want 4 1 0", cur_state, update, flap_out);
      end
      auto_fd = 1'b0;
      finished_draw = 1'b0;
   endtask

   task automatic test_collision();
      do_reset();
      finished_draw = 1'b1;
      collision = 1'b1;
      wall_passed = 1'b1;
      pulse_start();
      for (int i = 0; i < 100 && m_state != 7; i++) next_cycle();
      vec_count++;
      if (cur_state !== 4'd7 || game_over !== 1'b1 || score !== 8'd1) begin
         miscompares++;
         $display("[TB] FAIL game_over: state=%0d go=%b score=%0d want 7 1 1", cur_state, game_over, score);
      end
      for (int i = 0; i < 5; i++) next_cycle();
      vec_count++;
      if (cur_state !== 4'd7 || score !== 8'd1) begin
         miscompares++;
         $display("[TB] FAIL game_over_hold: state=%0d score=%0d want 7 1", cur_state, score);
      end
      collision = 1'b0;
      start = 1'b1;
      next_cycle();
      vec_count++;
      if (cur_state !== 4'd6 || game_over !== 1'b0 || score !== 8'd1) begin
         miscompares++;
         $display("[TB] FAIL over_to_idle: state=%0d go=%b score=%0d want 6 0 1", cur_state, game_over, score);
      end
      next_cycle();
      start = 1'b0;
      vec_count++;
      if (cur_state !== 4'd3 || score !== 8'd0) begin
         miscompares++;
         $display("[TB] FAIL restart_clear: state=%0d score=%0d want 3 0", cur_state, score);
      end
      finished_draw = 1'b0;
      wall_passed = 1'b0;
   endtask

   task automatic test_saturation();
      do_reset();
      finished_draw = 1'b1;
      wall_passed = 1'b1;
      pulse_start();
      for (int i = 0; i < 10000 && m_score != 254; i++) next_cycle();
      vec_count++;
      if (score !== 8'd254) begin
         miscompares++;
         $display("[TB] FAIL score_254: score=%0d want 254", score);
      end
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 100 && m_state != 4; i++) next_cycle();
         next_cycle();
         vec_count++;
         if (score !== 8'd255) begin
            miscompares++;
            $display("[TB] FAIL score_sat[%0d]: score=%0d want 255", k, score);
         end
      end
      finished_draw = 1'b0;
      wall_passed = 1'b0;
   endtask

   task automatic test_reset_mid_draw();
      do_reset();
      finished_draw = 1'b1;
      wall_passed = 1'b1;
      pulse_start();
      for (int i = 0; i < 100 && m_state != 1; i++) next_cycle();
      finished_draw = 1'b0;
      flap = 1'b1;
      next_cycle();
      #2;
      reset = 1'b1;
      #1;
      vec_count++;
      if (cur_state !== 4'd6 || score !== 8'd0 || update !== 1'b0 || flap_out !== 1'b0 || game_over !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_abort: state=%0d score=%0d upd=%b fo=%b go=%b want 6 0 0 0 0",
                  cur_state, score, update, flap_out, game_over);
      end
      flap = 1'b0;
      wall_passed = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      finished_draw = 1'b1;
      pulse_start();
      for (int i = 0; i < 100 && m_state != 4; i++) next_cycle();
      vec_count++;
      if (cur_state !== 4'd4 || update !== 1'b1 || flap_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL pending_cleared: state=%0d upd=%b fo=%b want 4 1 0", cur_state, update, flap_out);
      end
      finished_draw = 1'b0;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         next_cycle();
         start         = ($urandom % 16) == 0;
         flap          = ($urandom % 8) == 0;
         finished_draw = ($urandom % 3) == 0;
         collision     = ($urandom % 4) == 0;
         wall_passed   = ($urandom % 2) == 0;
         #1;
         vec_count++;
         if (cur_state !== 4'(m_state) || score !== 8'(m_score)
             || update !== (m_state == 4) || game_over !== (m_state == 7)
             || flap_out !== ((m_state == 4) && (m_pend || flap))) begin
            miscompares++;
            $display("[TB] FAIL random[%0d]: state=%0d score=%0d upd=%b fo=%b go=%b want %0d %0d %b %b %b",
                     i, cur_state, score, update, flap_out, game_over, m_state, m_score,
                     m_state == 4, (m_state == 4) && (m_pend || flap), m_state == 7);
         end
      end
      start = 1'b0; flap = 1'b0; finished_draw = 1'b0;
      collision = 1'b0; wall_passed = 1'b0;
   endtask

   // Scenario sequence followed by the summary.
   initial begin
      #1;
      test_reset();
      test_frame_sequence();
      test_flap();
      test_collision();
      test_saturation();
      test_reset_mid_draw();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule
